// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and counter sizing for the UART transmitter arbiter
//
// Purpose : FSM state type and the counter-width helper used to size both
//           timeout counters of uart_tx_arbiter.
// Ports   : none (package).

package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_t;

    // Width of a counter that must hold 0 .. max_count-1.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
//
// Purpose : picks the first set request scanning from ptr+1 upward and
//           wrapping modulo N, so the requester at ptr is considered last.
// Ports   : req   in  N   request vector
//           ptr   in  IW  index of the most recently served requester
//           pick  out N   one-hot winner (all-zero when no request)
//           idx   out IW  index of the winner (0 when no request)
//           found out 1   any request present

module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int c;
        c     = 0;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found   = 1'b1;
                pick[c] = 1'b1;
                idx     = IW'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin sharing of one UART transmitter
//
// Purpose : grants the transmitter to one requester for a whole packet, feeds
//           its bytes through a tx_start / tx_busy handshake and recovers from
//           a transmitter that never starts or a requester that stalls.
// Ports   : clk        in  1          system clock
//           reset      in  1          synchronous active-high reset
//           req_valid  in  NUM_REQ    per-requester byte valid
//           req_data   in  8*NUM_REQ  byte of requester i at [8i+7:8i]
//           req_last   in  NUM_REQ    final byte of a packet
//           req_ready  out NUM_REQ    byte accepted this cycle
//           grant      out NUM_REQ    one-hot owner, zero when idle
//           tx_data    out 8          byte to transmitter
//           tx_start   out 1          one-cycle start pulse
//           tx_busy    in  1          transmitter serialising
//           err_start  out 1          sticky start-timeout flag
//           err_hold   out 1          sticky hold-timeout flag

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = 16,
    parameter int HOLD_TIMEOUT  = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 err_start,
    output logic                 err_hold
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = cnt_width(START_TIMEOUT);
    localparam int HW = cnt_width(HOLD_TIMEOUT);
    localparam logic [SW-1:0] START_LAST = SW'(START_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_RESET  = IW'(NUM_REQ - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 last_q, last_d;
    logic                 err_start_q, err_start_d;
    logic                 err_hold_q, err_hold_d;
    logic [SW-1:0]        start_cnt_q, start_cnt_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0]   pick;
    logic [IW-1:0]        pick_idx;
    logic                 pick_found;

    logic                 owner_valid;
    logic                 owner_last;
    logic [7:0]           owner_data;

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .pick  (pick),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The owner's index is kept alongside the one-hot grant so its byte lanes
    // can be muxed without a one-hot-to-binary encoder.
    assign owner_valid = req_valid[gidx_q];
    assign owner_last  = req_last[gidx_q];
    assign owner_data  = req_data[{gidx_q, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        last_d      = last_q;
        err_start_d = err_start_q;
        err_hold_d  = err_hold_q;
        start_cnt_d = start_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    state_d = XFER;
                end
            end

            XFER: begin
                req_ready = grant_q & req_valid;
                if (owner_valid) begin
                    tx_data_d   = owner_data;
                    tx_start_d  = 1'b1;
                    last_d      = owner_last;
                    hold_cnt_d  = '0;
                    start_cnt_d = '0;
                    state_d     = WAIT_HI;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    err_hold_d = 1'b1;
                    grant_d    = '0;
                    ptr_d      = gidx_q;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end

            // The pulse cycle counts toward the timeout, but busy seen while
            // the pulse is still out is stale and must not end the wait.
            WAIT_HI: begin
                if (!tx_start_q && tx_busy) begin
                    start_cnt_d = '0;
                    state_d     = WAIT_LO;
                end else if (start_cnt_q == START_LAST) begin
                    err_start_d = 1'b1;
                    start_cnt_d = '0;
                    state_d     = WAIT_LO;
                end else begin
                    start_cnt_d = start_cnt_q + SW'(1);
                end
            end

            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = gidx_q;
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= PTR_RESET;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            last_q      <= 1'b0;
            err_start_q <= 1'b0;
            err_hold_q  <= 1'b0;
            start_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            last_q      <= last_d;
            err_start_q <= err_start_d;
            err_hold_q  <= err_hold_d;
            start_cnt_q <= start_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign err_start = err_start_q;
    assign err_hold  = err_hold_q;

endmodule
